// File: rtl/c432_key_loader.sv
// c432_key_loader: receives the unlock key for the locked c432 core one bit at a
// time from the key store and collects the bits in a shadow register. When the
// whole key is in, it is copied to key_out in a single cycle and key_valid is
// raised.
// Optional build macro C432_KEY_PARITY_EN: one even-parity bit follows the key
// bits and is checked before the key is committed.
// Handshake: a bit moves from the key store into the shadow register on every
// rising edge where key_req and key_vld are both high. key_req is driven only
// by registered state. The key store must hold key_bit steady until that
// transfer happens.
module c432_key_loader #(
    parameter int KEY_W   = 23,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             zeroize,
    output logic             key_req,
    input  logic             key_vld,
    input  logic             key_bit,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam int BW = $clog2(KEY_W + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
`ifdef C432_KEY_PARITY_EN
        S_PAR    = 3'd2,
`endif
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [KEY_W-1:0] key_out_d;
    logic             key_valid_d, key_req_d, busy_d, err_d;
    logic             take;

    // Register a bit on a transfer cycle. key_req is a flop output, so this has
    // no path from inputs to outputs.
    assign take      = key_req && key_vld;
    assign dbg_state = state_q;

    // Next-state and next-register logic. zeroize is applied last, so it
    // overrides every other assignment, including a start in the same cycle.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        key_out_d   = key_out;
        key_valid_d = key_valid;
        err_d       = err;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    // Starting a load always discards the current key and any error.
                    state_d     = S_LOAD;
                    shadow_d    = '0;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    key_out_d   = '0;
                    key_valid_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            S_LOAD: begin
                if (take) begin
                    shadow_d[bit_cnt_q] = key_bit;
                    bit_cnt_d           = bit_cnt_q + BW'(1);
                    to_cnt_d            = '0;
                    if (bit_cnt_q == BW'(KEY_W - 1)) begin
`ifdef C432_KEY_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_COMMIT;
`endif
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                    key_out_d   = '0;
                    key_valid_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
`ifdef C432_KEY_PARITY_EN
            S_PAR: begin
                if (take) begin
                    to_cnt_d = '0;
                    // Even parity: the key bits XORed with the parity bit must be 0.
                    if ((^shadow_q ^ key_bit) == 1'b0) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d     = S_ERROR;
                        err_d       = 1'b1;
                        key_out_d   = '0;
                        key_valid_d = 1'b0;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                    key_out_d   = '0;
                    key_valid_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
`endif
            S_COMMIT: begin
                // The locked core only ever sees a complete key, copied in one cycle.
                key_out_d   = shadow_q;
                key_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (zeroize) begin
            state_d     = S_IDLE;
            shadow_d    = '0;
            bit_cnt_d   = '0;
            to_cnt_d    = '0;
            key_out_d   = '0;
            key_valid_d = 1'b0;
            err_d       = 1'b0;
        end

        key_req_d = (state_d == S_LOAD);
`ifdef C432_KEY_PARITY_EN
        key_req_d = key_req_d || (state_d == S_PAR);
`endif
        busy_d = key_req_d || (state_d == S_COMMIT);
    end

    // State and output registers. The reset is asynchronous, so no partial key
    // can stay visible on key_out after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            key_req   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            key_out   <= key_out_d;
            key_valid <= key_valid_d;
            key_req   <= key_req_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed testbench for c432_key_loader. It also runs with C432_KEY_PARITY_EN
// defined.
module tb_c432_key_loader;

    localparam int KEY_W   = 23;
    localparam int TIMEOUT = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             zeroize;
    logic             key_req;
    logic             key_vld;
    logic             key_bit;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;
    logic [2:0]       dbg_state;

    logic [KEY_W-1:0] exp_q[$];
    int               n_vec;
    int               n_err;

    c432_key_loader #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .zeroize   (zeroize),
        .key_req   (key_req),
        .key_vld   (key_vld),
        .key_bit   (key_bit),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Wait for the next edge; drive inputs and sample outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete load.
    // toggle: key_vld alternates 1/0, starting with 1 just after E0.
    // poke_start: pulses start partway through the load; it must be ignored.
    // par_ok: the parity bit is expected to be accepted.
    task automatic load_key(input logic [KEY_W-1:0] key, input bit toggle,
                            input logic par_bit, input bit par_ok, input bit poke_start);
        int e, idx, nb, guard, busy_lo, leak, last_edge, valid_edge;
        bit acc;
        nb = KEY_W;
`ifdef C432_KEY_PARITY_EN
        nb = KEY_W + 1;
`endif
        last_edge  = toggle ? (2 * nb - 1) : nb;
        valid_edge = last_edge + 1;
        if (par_ok) exp_q.push_back(key);
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        check("load_req_rise", key_req, 1);
        idx = 0; guard = 0; busy_lo = 0; leak = 0;
        while (idx < nb && guard < 4 * nb + 8) begin
            key_vld = toggle ? ((e % 2) == 0) : 1'b1;
            key_bit = (idx < KEY_W) ? key[idx] : par_bit;
            start   = poke_start && (e == 10);
            acc     = key_req && key_vld;
            tick();
            e++;
            guard++;
            if (acc) idx++;
            if (idx < nb && !busy) busy_lo++;
            if (key_out != '0 || key_valid) leak++;
        end
        key_vld = 1'b0;
        start   = 1'b0;
        check("load_last_edge", e, last_edge);
        check("load_busy_during", busy_lo, 0);
        check("load_no_partial", leak, 0);
        check("load_req_fall", key_req, 0);
        if (par_ok) begin
            check("commit_busy", busy, 1);
            check("commit_valid_low", key_valid, 0);
            tick();
            e++;
            check("valid_edge", e, valid_edge);
            check("key_valid", key_valid, 1);
            check("key_out", key_out, exp_q.pop_front());
            check("done_err", err, 0);
            check("done_busy", busy, 0);
            check("done_state", dbg_state, ST_DONE);
        end else begin
            check("par_err", err, 1);
            check("par_key_out", key_out, 0);
            check("par_key_valid", key_valid, 0);
            check("par_busy", busy, 0);
            check("par_state", dbg_state, ST_ERROR);
        end
    endtask

    logic [KEY_W-1:0] k;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        zeroize = 1'b0;
        key_vld = 1'b0;
        key_bit = 1'b0;

        // Reset values.
        repeat (3) tick();
        check("rst_key_req", key_req, 0);
        check("rst_key_out", key_out, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load with key_vld held high (parity of 55AA33 is even, so the parity bit is 0).
        load_key(23'h55AA33, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reload from DONE with key_vld toggling, plus a start pulse during the load that must be ignored.
        load_key(23'h55AA33, 1'b1, 1'b0, 1'b1, 1'b1);

        // Timeout: bits 0..5 go in, then 64 idle cycles.
        k = 23'h55AA33;
        start = 1'b1;
        tick();
        start = 1'b0;
        key_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key_bit = k[i];
            tick();
        end
        key_vld = 1'b0;
        repeat (TIMEOUT - 1) tick();
        check("to_err_early", err, 0);
        check("to_busy_early", busy, 1);
        tick();
        check("to_err", err, 1);
        check("to_key_out", key_out, 0);
        check("to_busy", busy, 0);
        check("to_key_req", key_req, 0);
        check("to_state", dbg_state, ST_ERROR);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_restart_err", err, 0);
        check("to_restart_req", key_req, 1);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zero_load_state", dbg_state, ST_IDLE);
        check("zero_load_req", key_req, 0);

`ifdef C432_KEY_PARITY_EN
        // Odd key with parity bit 0 must be rejected; the same key with parity bit 1 must be accepted.
        load_key(23'h000001, 1'b0, 1'b0, 1'b0, 1'b0);
        load_key(23'h000001, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // zeroize and start asserted together while in DONE.
        load_key(23'h13579B, 1'b0, 1'b1, 1'b1, 1'b0);
        zeroize = 1'b1;
        start   = 1'b1;
        tick();
        zeroize = 1'b0;
        start   = 1'b0;
        check("zs_state", dbg_state, ST_IDLE);
        check("zs_key_out", key_out, 0);
        check("zs_key_valid", key_valid, 0);
        check("zs_key_req", key_req, 0);
        check("zs_busy", busy, 0);
        tick();
        check("zs_key_req_stays", key_req, 0);

        // Asynchronous reset after bit 10 has been accepted.
        k = 23'h2A5C7E;
        start = 1'b1;
        tick();
        start = 1'b0;
        key_vld = 1'b1;
        for (int i = 0; i < 11; i++) begin
            key_bit = k[i];
            tick();
        end
        check("mid_req_before", key_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", key_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_key_out", key_out, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_state", dbg_state, ST_IDLE);
        key_vld = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_state", dbg_state, ST_IDLE);
        // 2A5C7E has an odd number of 1 bits, so the even-parity bit is 1.
        load_key(23'h2A5C7E, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/c432_key_loader.md
# c432_key_loader

Sequential key-provisioning controller for the locked c432 interrupt-controller netlist. It fetches the KEY_W-bit unlock key bit-serially from the on-chip key store over a valid/request handshake. It assembles the bits in a shadow register and commits them atomically to the `keyinput*` bus of the locked core. It also raises `key_valid` so downstream logic can ungate the core's outputs (G223gat…G432gat) only once a complete, checked key is in place.

## Interface
Parameters:
- `KEY_W`, 23, key width; bit i drives `keyinput<i>` of the locked core.
- `TIMEOUT`, 64, maximum idle cycles between accepted key bits during a load; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  load request; one-cycle pulse, level tolerated.
- `zeroize`  in  1  synchronous clear of all key material; highest priority.
- `key_req`  out  1  controller ready to accept a key bit.
- `key_vld`  in  1  key store presents a bit on `key_bit`.
- `key_bit`  in  1  serial key data, LSB (keyinput0) first.
- `key_out`  out  KEY_W  committed key to the locked core.
- `key_valid`  out  1  `key_out` holds a complete, checked key.
- `busy`  out  1  load in progress (LOAD, PAR, or COMMIT).
- `err`  out  1  last load failed (timeout or parity); sticky until restart or zeroize.

## Operation
- States: IDLE, LOAD, PAR (macro only), COMMIT, DONE, ERROR.
- Reset: state=IDLE; `key_out`=0; shadow=0; `bit_cnt`=0; `to_cnt`=0; `key_req`=0; `key_valid`=0; `busy`=0; `err`=0.
- IDLE/DONE/ERROR + `start` → LOAD:
  - clear shadow, `bit_cnt`, `to_cnt`, `key_out`, `key_valid`, `err`.
  - In DONE, this discards the old key.
- LOAD:
  - `key_req`=1.
  - Bit accepted on a cycle with `key_req && key_vld`: shadow[`bit_cnt`] ← `key_bit`; `bit_cnt`++; `to_cnt` ← 0.
  - No bit accepted: `to_cnt`++.
  - `to_cnt` reaching TIMEOUT-1 without a bit → ERROR.
  - Acceptance of bit KEY_W-1 → COMMIT, or → PAR when the macro is defined.
- COMMIT (one cycle): `key_req`=0; `key_out` ← shadow; `key_valid` ← 1; → DONE.
- DONE: `key_out` and `key_valid` held; `start` starts a reload.
- ERROR: `err`=1; `key_out`=0; `key_valid`=0; `key_req`=0; wait for `start` or `zeroize`.
- `zeroize` in any state → IDLE next edge, with every register at its reset value. `zeroize` beats a simultaneous `start`.
- `start` while `busy` is ignored. No restart mid-load.
- `bit_cnt` width: $clog2(KEY_W+1). `to_cnt` width: $clog2(TIMEOUT).
- `busy`=1 exactly in LOAD, PAR, and COMMIT.

## Timing
- All outputs registered. No combinational path from inputs to outputs.
- `start` sampled at edge E0; `key_req` high from E0 onward.
- With `key_vld` held high, bits are accepted at E1…E_KEY_W.
- COMMIT occupies the cycle after E_KEY_W. `key_out`/`key_valid` update at E_KEY_W+1 (E_KEY_W+2 with parity).
- Back-pressure: `key_vld` may drop any cycle; a bit is transferred only when `key_req` and `key_vld` are both high. The store must hold `key_bit` until transferred.
- `key_req` falls on the edge the last bit (or parity bit) is accepted.
- Reset mid-load: asynchronous clear. No partial key ever appears on `key_out`.

## Configuration
- `C432_KEY_PARITY_EN` defined:
  - After KEY_W bits, PAR state keeps `key_req`=1 and accepts one more bit, the even-parity bit.
  - If XOR(shadow) ^ bit = 0 → COMMIT, else → ERROR.
  - The timeout counter applies in PAR.
- Undefined: PAR state, its logic, and the parity check are absent. LOAD goes directly to COMMIT.

## Test plan
- Load 23'h55AA33 with `key_vld` continuously high (parity bit 0 when enabled) → `key_out`=23'h55AA33, `key_valid`=1 at E24 (E25 with parity); `err`=0.
- Same key with `key_vld` toggling 1/0 each cycle → identical `key_out`; `key_valid` at E46 (E48 with parity); `busy` high throughout.
- Stall `key_vld` low for 64 cycles after bit 5 → ERROR at the 64th idle cycle; `err`=1, `key_out`=0. A later `start` clears `err`.
- With `C432_KEY_PARITY_EN`: key 23'h000001 with parity bit 0 → ERROR, `key_out`=0. Retry with parity bit 1 → `key_valid`=1.
- In DONE, assert `zeroize` and `start` together → IDLE, `key_out`=0, `key_valid`=0, `key_req` stays 0.
- Deassert `rst_n` after bit 10 → outputs 0 immediately. After release, the FSM is in IDLE and a full load succeeds.
